// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller driving one external full-adder cell, LSB first.
// Define SERIAL_ADD_OVF_EN to build the signed-overflow flop; otherwise ovf is tied low.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic carry, last;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  // The carry flop is the carry-out once the final RUN edge has passed.
  assign cout = carry;
  assign fa_a = busy & a_sh[0];
  assign fa_b = busy & b_sh[0];
  assign fa_c = busy & carry;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
          state <= RUN;
`ifdef SERIAL_ADD_OVF_EN
          ovf_r <= 1'b0;
`endif
        end
        RUN: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_cout;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          cnt   <= last ? '0 : cnt + 1'b1;
          state <= last ? DONE : RUN;
`ifdef SERIAL_ADD_OVF_EN
          if (last) ovf_r <= carry ^ fa_cout;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout, ovf, fa_a, fa_b, fa_c, fa_s, fa_cout;
  int errors = 0, checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_cout(fa_cout)
  );

  assign fa_s    = fa_a ^ fa_b ^ fa_c;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic carry_into(input logic [W-1:0] x, y, input logic c, input int i);
    int unsigned m, s;
    m = (32'd1 << i) - 1;
    s = (x & m) + (y & m) + c;
    return s[i];
  endfunction

  function automatic logic ovf_ref(input logic [W-1:0] x, y, input logic c);
    logic [W:0] r;
    r = x + y + c;
`ifdef SERIAL_ADD_OVF_EN
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_op(input logic [W-1:0] x, y, input logic c, input bit inj);
    logic [W:0] r;
    r = x + y + c;
    a = x; b = y; cin = c; start = 1;
    @(posedge clk); #1;
    start = 0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("fa_a", fa_a, x[i]);
      chk("fa_b", fa_b, y[i]);
      chk("fa_c", fa_c, carry_into(x, y, c, i));
      if (inj && i == 3) begin start = 1; a = 8'h01; b = 8'h00; end
      if (inj && i == 4) start = 0;
      @(posedge clk); #1;
    end
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("sum", sum, r[W-1:0]);
    chk("cout", cout, r[W]);
    chk("ovf", ovf, ovf_ref(x, y, c));
    chk("fa_idle", {fa_a, fa_b, fa_c}, 0);
    if (inj) start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_hold", sum, r[W-1:0]);
    chk("cout_hold", cout, r[W]);
    @(posedge clk); #1;
    chk("no_restart", busy, 0);
  endtask

  initial begin
    int last, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fa", {fa_a, fa_b, fa_c}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    do_op(8'h5A, 8'h33, 0, 0);
    do_op(8'hFF, 8'h01, 0, 0);
    do_op(8'h7F, 8'h01, 0, 0);
    do_op(8'hFF, 8'hFF, 1, 0);
    // Held start: a new operation is taken every WIDTH+2 cycles.
    a = 8'hFF; b = 8'hFF; cin = 1; start = 1;
    last = -1; n = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        chk("held_sum", sum, 8'hFF);
        chk("held_cout", cout, 1);
        if (last >= 0) chk("held_period", cyc - last, W + 2);
        last = cyc;
        n++;
      end
    end
    chk("held_count", n >= 3, 1);
    start = 0;
    repeat (W + 3) @(posedge clk);
    #1;
    chk("held_idle", busy, 0);
    do_op(8'h0F, 8'hF0, 0, 1);
    // Asynchronous reset in the middle of RUN.
    a = 8'hAA; b = 8'h55; cin = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_fa", {fa_a, fa_b, fa_c}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_nodone", done, 0);
    end
    rst_n = 1;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {busy, done}, 0);
    end
    do_op(8'hAA, 8'h55, 0, 0);
    for (int k = 0; k < 25; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
